// File: rtl/seven_segment_scan_driver.sv
// seven_segment_scan_driver: captures write commands into an 8-entry digit store and
// time-multiplexes it onto a common-anode, active-low display. Option: SEVSEG_LEADING_ZERO_BLANK_EN.
module seven_segment_scan_driver #(
  parameter int unsigned CLK_HZ       = 100000000,
  parameter int unsigned REFRESH_HZ   = 1000,
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic        sys_clk,
  input  logic        cpu_rst,
  input  logic [14:0] seven_segment_control_field,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [7:0]  an_n
);

  localparam int unsigned DIGIT_CYCLES = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int unsigned ON_CYCLES    = DIGIT_CYCLES - GUARD_CYCLES;
  localparam int unsigned CNT_W        = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [2:0]       IDX_LAST   = 3'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_GUARD = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  // Entry layout: [9] dp, [8] raw, [7] blank, [6:0] payload
  localparam logic [9:0] ENTRY_BLANK = 10'b0_0_1_0000000;

  if (DIGIT_CYCLES == 0 || GUARD_CYCLES == 0 || GUARD_CYCLES >= DIGIT_CYCLES ||
      NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_cfg
    $error("seven_segment_scan_driver: illegal timing/digit configuration");
  end

  logic             wr_q;
  logic             cmd_wr;
  logic [2:0]       cmd_addr;
  logic             commit;
  logic             unused_reserved;
  logic [9:0]       entry [8];
  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [9:0]       cur;
  logic [6:0]       cur_seg_n;
  logic             lz_blank;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  assign cmd_wr          = seven_segment_control_field[14];
  assign cmd_addr        = seven_segment_control_field[13:11];
  assign unused_reserved = seven_segment_control_field[7];
  // Out-of-range addresses never qualify, so those commands vanish without a trace
  assign commit = cmd_wr && !wr_q && ({1'b0, cmd_addr} < 4'(NUM_DIGITS));

  always_ff @(posedge sys_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      wr_q <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) entry[i] <= ENTRY_BLANK;
    end else begin
      wr_q <= cmd_wr;
      if (commit)
        entry[cmd_addr] <= {seven_segment_control_field[10:8], seven_segment_control_field[6:0]};
    end
  end

  always_ff @(posedge sys_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state <= ST_GUARD;
      cnt   <= '0;
      idx   <= '0;
    end else if (state == ST_GUARD) begin
      if (cnt == GUARD_LAST) begin
        state <= ST_ON;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      if (cnt == ON_LAST) begin
        state <= ST_GUARD;
        cnt   <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
  logic [7:0] lz;
  logic       run_z;

  // Walk down from the top scanned digit; the run of blankable zeros stops at the first other entry
  always_comb begin
    lz    = '0;
    run_z = 1'b1;
    for (int unsigned k = 0; k < 7; k++) begin
      if ((7 - k) < NUM_DIGITS) begin
        run_z     = run_z && (entry[7 - k][9:7] == 3'b000) && (entry[7 - k][3:0] == 4'h0);
        lz[7 - k] = run_z;
      end
    end
  end

  assign lz_blank = lz[idx];
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    cur       = entry[idx];
    cur_seg_n = '1;
    if (cur[7] || lz_blank) cur_seg_n = '1;
    else if (cur[8])        cur_seg_n = ~cur[6:0];
    else                    cur_seg_n = hex_seg(cur[3:0]);
  end

  always_ff @(posedge sys_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      an_n  <= '1;
      seg_n <= '1;
      dp_n  <= 1'b1;
    end else if (state == ST_ON) begin
      an_n  <= ~(8'h01 << idx);
      seg_n <= cur_seg_n;
      dp_n  <= ~cur[9];
    end else begin
      an_n  <= '1;
      seg_n <= '1;
      dp_n  <= 1'b1;
    end
  end

endmodule
